// File: rtl/wavelet_l3_stream.sv
`default_nettype none
// ============================================================================
// wavelet_l3_stream : level-3 Haar approximation stream with ping-pong windowed peak search
// Revision: 1.0
// ============================================================================
module wavelet_l3_stream #(
  parameter int DW        = 17,
  parameter int LEVELS    = 3,
  parameter int DEPTH     = 100,
  parameter int PW        = 12,
  parameter int THR_SHIFT = 1,
  parameter int ABS_MODE  = 0
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic                      push_data,
  input  logic [(2**LEVELS)*DW-1:0] data_in,
  output logic                      peak_valid,
  input  logic                      peak_ready,
  output logic [DW+LEVELS-1:0]      r_peak,
  output logic [PW-1:0]             r_peak_pos,
  output logic [DW+LEVELS-1:0]      thr,
  output logic                      overrun,
  output logic                      busy
);

  localparam int LANES = 2**LEVELS;
  localparam int CW    = DW + LEVELS;
  localparam int MW    = CW + 1;
  localparam int OW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [OW-1:0] LAST_OFF = OW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [CW-1:0] ca_sum;
  logic signed [CW-1:0] ca_reg;
  logic                 ca_vld;

  logic                 wr_bank;
  logic [OW-1:0]        wr_off;
  logic [PW-1:0]        gidx;
  logic [1:0]           full;
  logic [1:0][PW-1:0]   base_idx;
  logic                 wr_en;
  logic                 wr_drop;
  logic                 wr_last;

  logic signed [CW-1:0] bank_mem [2][DEPTH];

  logic                 scan_bank;
  logic [OW-1:0]        scan_off;
  logic signed [CW-1:0] scan_val;
  logic signed [CW-1:0] best_val;
  logic [OW-1:0]        best_off;
  logic signed [CW-1:0] win_val;
  logic [OW-1:0]        win_off;
  logic                 cand_better;
  logic                 scan_done;
  logic                 bank_ready;
  logic                 handshake;

  // Magnitude one bit wider so the most negative value compares above every positive one.
  function automatic logic [MW-1:0] magnitude(input logic signed [CW-1:0] v);
    logic signed [MW-1:0] ext;
    ext = MW'(v);
    return v[CW-1] ? $unsigned(-ext) : $unsigned(ext);
  endfunction

  always_comb begin
    ca_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      ca_sum = ca_sum + CW'($signed(data_in[k*DW +: DW]));
    end
  end

  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      ca_vld <= 1'b0;
      ca_reg <= '0;
    end else begin
      ca_vld <= push_data;
      if (push_data) begin
        ca_reg <= ca_sum;
      end
    end
  end

  assign wr_en   = ca_vld & ~full[wr_bank];
  assign wr_drop = ca_vld &  full[wr_bank];
  assign wr_last = wr_en & (wr_off == LAST_OFF);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_mem[wr_bank][wr_off] <= ca_reg;
    end
  end

  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      wr_bank  <= 1'b0;
      wr_off   <= '0;
      gidx     <= '0;
      base_idx <= '0;
      overrun  <= 1'b0;
    end else begin
      if (wr_drop) begin
        overrun <= 1'b1;
      end
      if (wr_en) begin
        if (wr_off == '0) begin
          base_idx[wr_bank] <= gidx;
        end
        gidx <= gidx + PW'(1);
        if (wr_last) begin
          wr_off  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_off <= wr_off + OW'(1);
        end
      end
    end
  end

  // A bank is released once its scan finishes; the result registers keep the answer.
  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      full <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_last && (wr_bank == b[0])) begin
          full[b] <= 1'b1;
        end else if (scan_done && (scan_bank == b[0])) begin
          full[b] <= 1'b0;
        end
      end
    end
  end

  assign scan_val   = bank_mem[scan_bank][scan_off];
  assign scan_done  = (state == SCAN) && (scan_off == LAST_OFF);
  assign bank_ready = full[scan_bank] | (wr_last & (wr_bank == scan_bank));
  assign handshake  = peak_valid & peak_ready;

  generate
    if (ABS_MODE != 0) begin : g_abs_cmp
      logic [MW-1:0] mag_new;
      logic [MW-1:0] mag_best;
      assign mag_new     = magnitude(scan_val);
      assign mag_best    = magnitude(best_val);
      assign cand_better = mag_new > mag_best;
    end else begin : g_sgn_cmp
      assign cand_better = scan_val > best_val;
    end
  endgenerate

  // Strictly-greater update keeps the first occurrence on ties.
  always_comb begin
    win_val = best_val;
    win_off = best_off;
    if ((scan_off == '0) || cand_better) begin
      win_val = scan_val;
      win_off = scan_off;
    end
  end

  always_comb begin
    state_nxt  = state;
    peak_valid = (state == REPORT);
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (bank_ready) state_nxt = SCAN;
      SCAN:    if (scan_off == LAST_OFF) state_nxt = REPORT;
      REPORT:  if (handshake) state_nxt = bank_ready ? SCAN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge nReset) begin
    if (nReset) begin
      scan_bank  <= 1'b0;
      scan_off   <= '0;
      best_val   <= '0;
      best_off   <= '0;
      r_peak     <= '0;
      r_peak_pos <= '0;
      thr        <= '0;
    end else begin
      if (state == SCAN) begin
        best_val <= win_val;
        best_off <= win_off;
        scan_off <= scan_done ? '0 : scan_off + OW'(1);
      end
      if (scan_done) begin
        scan_bank  <= ~scan_bank;
        r_peak     <= win_val;
        r_peak_pos <= base_idx[scan_bank] + PW'(win_off);
        thr        <= win_val >>> THR_SHIFT;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wavelet_l3_stream.sv
`default_nettype none
// Bench for wavelet_l3_stream at DEPTH=4: one instance per search mode, checked against a window-level model.
module tb_wavelet_l3_stream;
  localparam int DW    = 17;
  localparam int LEVELS = 3;
  localparam int DEPTH = 4;
  localparam int PW    = 12;
  localparam int LANES = 8;
  localparam int CW    = DW + LEVELS;

  logic clk, rst, push_data, peak_ready;
  logic [LANES*DW-1:0] data_in;
  logic pv0, pv1, ov0, ov1, busy0, busy1;
  logic [CW-1:0] pk0, pk1, th0, th1;
  logic [PW-1:0] pos0, pos1;

  wavelet_l3_stream #(.DW(DW), .LEVELS(LEVELS), .DEPTH(DEPTH), .PW(PW), .THR_SHIFT(1), .ABS_MODE(0)) u0 (
    .clk(clk), .nReset(rst), .push_data(push_data), .data_in(data_in),
    .peak_valid(pv0), .peak_ready(peak_ready), .r_peak(pk0), .r_peak_pos(pos0),
    .thr(th0), .overrun(ov0), .busy(busy0));

  wavelet_l3_stream #(.DW(DW), .LEVELS(LEVELS), .DEPTH(DEPTH), .PW(PW), .THR_SHIFT(1), .ABS_MODE(1)) u1 (
    .clk(clk), .nReset(rst), .push_data(push_data), .data_in(data_in),
    .peak_valid(pv1), .peak_ready(peak_ready), .r_peak(pk1), .r_peak_pos(pos1),
    .thr(th1), .overrun(ov1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  typedef struct { int v; int p; int t; } res_t;
  res_t exp0[$];
  res_t exp1[$];
  int   win[$];
  int   win_base = 0;
  int   m_gidx = 0;
  int   ln [LANES];

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic model_accept(input int s);
    int b0, b1;
    res_t r;
    if (win.size() == 0) win_base = m_gidx;
    win.push_back(s);
    m_gidx = (m_gidx + 1) % 4096;
    if (win.size() == DEPTH) begin
      b0 = 0;
      b1 = 0;
      for (int i = 1; i < DEPTH; i++) begin
        if (win[i] > win[b0]) b0 = i;
        if (iabs(win[i]) > iabs(win[b1])) b1 = i;
      end
      r.v = win[b0]; r.p = (win_base + b0) % 4096; r.t = win[b0] >>> 1;
      exp0.push_back(r);
      r.v = win[b1]; r.p = (win_base + b1) % 4096; r.t = win[b1] >>> 1;
      exp1.push_back(r);
      win.delete();
    end
  endtask

  task automatic model_flush();
    exp0.delete();
    exp1.delete();
    win.delete();
    m_gidx = 0;
  endtask

  task automatic drive(input bit p, input bit drop);
    int s;
    s = 0;
    push_data = p;
    for (int k = 0; k < LANES; k++) begin
      data_in[k*DW +: DW] = ln[k][DW-1:0];
      s += ln[k];
    end
    if (p && !drop) model_accept(s);
    @(posedge clk); #1;
  endtask

  task automatic push_same(input int v, input bit drop);
    for (int k = 0; k < LANES; k++) ln[k] = v;
    drive(1'b1, drop);
  endtask

  task automatic push_ca(input int c, input bit drop);
    int q;
    q = c / 8;
    for (int k = 1; k < LANES; k++) ln[k] = q;
    ln[0] = c - 7 * q;
    drive(1'b1, drop);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      push_data = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_pv(input int budget, input string name);
    int n;
    n = 0;
    while (!pv0 && n < budget) begin
      idle(1);
      n++;
    end
    chk({name, "_pv_timeout"}, int'(pv0), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_u0_pv"}, int'(pv0), 0);
    chk({tag, "_u0_peak"}, int'(pk0), 0);
    chk({tag, "_u0_pos"}, int'(pos0), 0);
    chk({tag, "_u0_thr"}, int'(th0), 0);
    chk({tag, "_u0_ovr"}, int'(ov0), 0);
    chk({tag, "_u0_busy"}, int'(busy0), 0);
    chk({tag, "_u1_pv"}, int'(pv1), 0);
    chk({tag, "_u1_peak"}, int'(pk1), 0);
    chk({tag, "_u1_pos"}, int'(pos1), 0);
    chk({tag, "_u1_thr"}, int'(th1), 0);
    chk({tag, "_u1_ovr"}, int'(ov1), 0);
    chk({tag, "_u1_busy"}, int'(busy1), 0);
  endtask

  // Result check: while valid the outputs must equal the oldest pending model result.
  task automatic cmp_unit(input int u, input bit pv, input bit bz, input int v, input int p, input int t);
    res_t e;
    string tag;
    bit empty;
    tag = (u == 0) ? "u0" : "u1";
    empty = (u == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
    if (pv) begin
      chk({tag, "_busy_in_report"}, int'(bz), 1);
      if (empty) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s_result: got peak_valid=1 value %0d, required no pending result", tag, v);
      end else begin
        e = (u == 0) ? exp0[0] : exp1[0];
        chk({tag, "_peak"}, v, e.v);
        chk({tag, "_pos"}, p, e.p);
        chk({tag, "_thr"}, t, e.t);
        if (peak_ready) begin
          if (u == 0) void'(exp0.pop_front());
          else        void'(exp1.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp_unit(0, pv0, busy0, int'($signed(pk0)), int'(pos0), int'($signed(th0)));
      cmp_unit(1, pv1, busy1, int'($signed(pk1)), int'(pos1), int'($signed(th1)));
    end
  end

  initial begin
    rst = 1'b1;
    push_data = 1'b0;
    peak_ready = 1'b1;
    data_in = '0;
    for (int k = 0; k < LANES; k++) ln[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    idle(1);

    // basic window: cA 8,16,80,24
    push_same(1, 1'b0); push_same(2, 1'b0); push_same(10, 1'b0); push_same(3, 1'b0);
    idle(4);
    chk("lat_pv_early", int'(pv0), 0);
    chk("scan_busy", int'(busy0), 1);
    idle(1);
    chk("lat_pv", int'(pv0), 1);
    chk("w1_peak", int'($signed(pk0)), 80);
    chk("w1_pos", int'(pos0), 2);
    chk("w1_thr", int'($signed(th0)), 40);
    chk("w1_abs_peak", int'($signed(pk1)), 80);
    idle(2);

    // tie at offsets 1 and 2, then an all-equal window
    push_ca(5, 1'b0); push_ca(9, 1'b0); push_ca(9, 1'b0); push_ca(1, 1'b0);
    wait_pv(20, "w2");
    chk("w2_peak", int'($signed(pk0)), 9);
    chk("w2_pos", int'(pos0), 5);
    idle(2);
    push_ca(7, 1'b0); push_ca(7, 1'b0); push_ca(7, 1'b0); push_ca(7, 1'b0);
    wait_pv(20, "w3");
    chk("w3_pos", int'(pos0), 8);
    idle(2);

    // signed vs magnitude search on the same data
    push_ca(40, 1'b0); push_ca(-50, 1'b0); push_ca(10, 1'b0); push_ca(0, 1'b0);
    wait_pv(20, "w4");
    chk("w4_sgn_peak", int'($signed(pk0)), 40);
    chk("w4_sgn_pos", int'(pos0), 12);
    chk("w4_abs_peak", int'($signed(pk1)), -50);
    chk("w4_abs_pos", int'(pos1), 13);
    chk("w4_abs_thr", int'($signed(th1)), -25);
    idle(2);

    // extremes: most negative cA outranks the largest positive in magnitude
    push_same(-65536, 1'b0); push_same(65535, 1'b0); push_same(-65536, 1'b0); push_same(0, 1'b0);
    wait_pv(20, "w5");
    chk("w5_sgn_peak", int'($signed(pk0)), 524280);
    chk("w5_sgn_pos", int'(pos0), 17);
    chk("w5_sgn_thr", int'($signed(th0)), 262140);
    chk("w5_abs_peak", int'($signed(pk1)), -524288);
    chk("w5_abs_pos", int'(pos1), 16);
    chk("w5_abs_thr", int'($signed(th1)), -262144);
    idle(2);

    // backpressure: result held, 9th extra push dropped
    peak_ready = 1'b0;
    push_ca(11, 1'b0); push_ca(22, 1'b0); push_ca(33, 1'b0); push_ca(44, 1'b0);
    wait_pv(20, "bpA");
    push_ca(3, 1'b0); push_ca(9, 1'b0); push_ca(2, 1'b0); push_ca(1, 1'b0);
    push_ca(8, 1'b0); push_ca(6, 1'b0); push_ca(7, 1'b0); push_ca(5, 1'b0);
    push_ca(99, 1'b1);
    idle(3);
    chk("bp_overrun_u0", int'(ov0), 1);
    chk("bp_overrun_u1", int'(ov1), 1);
    chk("bp_hold_pv", int'(pv0), 1);
    chk("bp_hold_peak", int'($signed(pk0)), 44);
    chk("bp_hold_pos", int'(pos0), 23);
    peak_ready = 1'b1;
    idle(1);
    wait_pv(20, "bpB");
    chk("bpB_pos", int'(pos0), 25);
    idle(1);
    wait_pv(20, "bpC");
    chk("bpC_pos", int'(pos0), 28);
    idle(2);

    // run the global index up to and across the 4095 -> 0 wrap
    for (int i = 32; i < 4092; i++) begin
      push_ca(((i * 73) % 501) - 250, 1'b0);
      idle(1);
    end
    push_ca(1, 1'b0); idle(1); push_ca(2, 1'b0); idle(1);
    push_ca(3, 1'b0); idle(1); push_ca(50, 1'b0);
    wait_pv(20, "wrapA");
    chk("wrapA_pos", int'(pos0), 4095);
    idle(2);
    push_ca(1, 1'b0); idle(1); push_ca(2, 1'b0); idle(1);
    push_ca(60, 1'b0); idle(1); push_ca(3, 1'b0);
    wait_pv(20, "wrapB");
    chk("wrapB_pos", int'(pos0), 2);
    idle(2);

    // reset during SCAN aborts the window
    push_ca(10, 1'b0); push_ca(20, 1'b0); push_ca(30, 1'b0); push_ca(40, 1'b0);
    idle(2);
    chk("pre_reset_busy", int'(busy0), 1);
    rst = 1'b1;
    model_flush();
    #1;
    chk_zero("midscan_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);
    chk("post_reset_no_pv", int'(pv0), 0);
    push_ca(3, 1'b0); push_ca(1, 1'b0); push_ca(4, 1'b0); push_ca(1, 1'b0);
    wait_pv(20, "fresh");
    chk("fresh_peak", int'($signed(pk0)), 4);
    chk("fresh_pos", int'(pos0), 2);
    chk("fresh_overrun", int'(ov0), 0);
    idle(3);
    chk("pending_results", exp0.size() + exp1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wavelet_l3_stream.md
WAVELET_L3_STREAM -- requirements
Module: wavelet_l3_stream

Interface
REQ-001 The block SHALL have the parameter DW, default 17, giving the signed input sample width.
REQ-002 The block SHALL have the parameter LEVELS, default 3; LANES = 2^LEVELS samples arrive per push.
REQ-003 The block SHALL have the parameter DEPTH, default 100, giving the number of cA coefficients per analysis window (2..1023).
REQ-004 The block SHALL have the parameter PW, default 12, giving the width of the position counter.
REQ-005 The block SHALL have the parameter THR_SHIFT, default 1, giving the threshold shift.
REQ-006 The block SHALL have the parameter ABS_MODE, default 0: 0 = signed-maximum search, 1 = largest-magnitude search.
REQ-007 The block SHALL have these ports:
- clk  in  1  sole clock; all state changes on its rising edge.
- nReset  in  1  asynchronous reset, active-high.
- push_data  in  1  one set of LANES samples valid this cycle.
- data_in  in  LANES*DW  signed samples; lane k at [k*DW +: DW], lane 0 oldest.
- peak_valid  out  1  window result available.
- peak_ready  in  1  consumer accepts the result.
- r_peak  out  DW+LEVELS  signed cA value of the peak.
- r_peak_pos  out  PW  global cA index of the peak.
- thr  out  DW+LEVELS  signed detection threshold.
- overrun  out  1  sticky: a push was dropped.
- busy  out  1  scan or report in progress.

Function
REQ-008 On each push_data cycle the block SHALL form cA as the signed sum of the LANES samples, computed at full width DW+LEVELS without overflow or truncation.
REQ-009 The block SHALL register cA one cycle after the push and write it to the active fill bank at offset wr_off; the global cA index SHALL then increment and wrap modulo 2^PW.
REQ-010 Storage SHALL be ping-pong: two banks of DEPTH entries each.
REQ-011 When a bank holds DEPTH entries, it SHALL be handed to the scanner and filling SHALL continue in the other bank with no lost cycle.
REQ-012 The scanner FSM SHALL have the states IDLE, SCAN and REPORT.
- IDLE -> SCAN on the cycle after a bank becomes full.
- SCAN reads one entry per cycle and lasts DEPTH cycles.
- SCAN -> REPORT on its last entry.
- REPORT -> IDLE when peak_valid && peak_ready, or -> SCAN directly if the other bank is already full.
REQ-013 The search SHALL use the signed maximum when ABS_MODE=0, and the largest |cA| when ABS_MODE=1.
REQ-014 When ABS_MODE=1, r_peak SHALL carry the signed original value, and |most-negative| SHALL compare correctly at width DW+LEVELS+1.
REQ-015 On ties, the lowest offset (first occurrence) SHALL win.
REQ-016 r_peak_pos SHALL equal the window base index plus the winning offset, modulo 2^PW.
REQ-017 thr SHALL equal r_peak >>> THR_SHIFT (arithmetic shift) and SHALL update together with r_peak.
REQ-018 peak_valid SHALL assert in the cycle after SCAN ends.
- r_peak, r_peak_pos and thr SHALL hold stable while peak_valid=1 && peak_ready=0.
- peak_valid SHALL deassert the cycle after the handshake, unless the next scan's result is already present.
REQ-019 End-to-end latency, with no backpressure, SHALL be DEPTH+2 cycles from the cycle of the completing push to peak_valid=1.
REQ-020 If a push arrives while the fill bank is full and the other bank is still in SCAN or REPORT, the push SHALL be dropped and overrun SHALL set.
- A dropped push SHALL not increment the global index.
- overrun SHALL clear only on reset.
REQ-021 When a push completes a bank in the same cycle as a handshake, both events SHALL take effect, and the next SCAN SHALL start without a bubble.
REQ-022 busy SHALL equal (state != IDLE).

Reset
REQ-023 While nReset=1 the following SHALL be held at 0: peak_valid, r_peak, r_peak_pos, thr, overrun, busy, the global index, the write offset and the bank select.
- The FSM SHALL be in IDLE.
- Bank contents need not be cleared.
REQ-024 Reset asserted mid-SCAN or mid-REPORT SHALL abort the operation immediately, with no result emitted after release.
REQ-025 The first push after reset release SHALL be processed normally.

Verification (DW=17, LEVELS=3, DEPTH=4, PW=12, THR_SHIFT=1, peak_ready=1 unless stated)
REQ-026 Basic window: 4 pushes with all lanes = 1, 2, 10, 3 -> cA = 8, 16, 80, 24; peak_valid 6 cycles after the 4th push; r_peak=80, r_peak_pos=2, thr=40.
REQ-027 Tie and continuation: window 2 with cA = 5, 9, 9, 1 -> r_peak=9, r_peak_pos=5; window 3 reports base index 8.
REQ-028 ABS_MODE=1, cA = 40, -50, 10, 0 -> r_peak=-50, r_peak_pos=1, thr=-25; with ABS_MODE=0 the same data -> r_peak=40, r_peak_pos=0.
REQ-029 Backpressure: peak_ready=0 after window 1, then 9 more pushes -> 9th push dropped, overrun=1, outputs stable; peak_ready=1 -> window 1 result, then window 2 immediately, r_peak_pos within 4..7.
REQ-030 Extremes: all lanes = -65536 -> cA = -524288 exact, no wrap; the global index wraps from 4095 to 0 and r_peak_pos follows modulo 4096.
REQ-031 Reset mid-SCAN: nReset=1 for 1 cycle during SCAN -> all outputs 0, no peak_valid; a fresh 4-push window reports r_peak_pos 0..3.
